uart_packet_loader: RTL

//   Host-side front end feeding the network control unit. Parses a byte stream

---
 rtl/uart_packet_loader_if.sv | 29 ++
 rtl/uart_packet_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_packet_loader_if.sv
// uart_packet_loader_if
//   Bundles the byte stream from the UART receiver, the ack handshake from the
//   network control unit, and the packet outputs presented to that unit.
//   master : byte source / control unit side (drives rx_data, rx_valid, ack)
//   slave  : the packet loader (drives start, train, label_out, image_out,
//            busy, err)
interface uart_packet_loader_if #(
  parameter int NUM_PX = 784
) ();
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  ack;
  logic                  start;
  logic                  train;
  logic [7:0]            label_out;
  logic [8*NUM_PX-1:0]   image_out;
  logic                  busy;
  logic                  err;

  modport master (
    output rx_data, rx_valid, ack,
    input  start, train, label_out, image_out, busy, err
  );

  modport slave (
    input  rx_data, rx_valid, ack,
    output start, train, label_out, image_out, busy, err
  );
endinterface

// File: rtl/uart_packet_loader.sv
// uart_packet_loader
//   Parses a UART byte stream into one command packet (command byte, optional
//   label byte, NUM_PX pixel bytes), presents image and label to the network
//   control unit, issues a start pulse (plus train for training packets) and
//   then holds off further packets until the control unit returns ack.
// Ports
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of uart_packet_loader_if
//          in : rx_data[7:0], rx_valid, ack
//          out: start, train, label_out[7:0], image_out[8*NUM_PX-1:0],
//               busy, err
//   Pixel i appears at image_out[8*i +: 8]. All outputs are registered.
module uart_packet_loader #(
  parameter int          NUM_PX       = 784,
  parameter logic [7:0]  CMD_CLASSIFY = 8'hC1,
  parameter logic [7:0]  CMD_TRAIN    = 8'hC2
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_packet_loader_if.slave   bus
);

  localparam int IMG_SZ = NUM_PX << 3;
  localparam int CNT_W  = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;
  localparam logic [CNT_W-1:0] LAST_PX = CNT_W'(NUM_PX - 1);

  typedef enum logic [2:0] {
    IDLE,
    LABEL,
    PIXELS,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic               is_train_q;
  logic               start_q;
  logic               train_q;
  logic               busy_q;
  logic               err_q;
  logic [7:0]         label_q;
  logic [IMG_SZ-1:0]  image_q;
  logic               pix_we;

  // A pixel is stored only while collecting pixels; bytes arriving in ISSUE
  // or WAIT_ACK never reach the image register.
  assign pix_we = (state_q == PIXELS) && bus.rx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      is_train_q <= 1'b0;
      start_q    <= 1'b0;
      train_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      label_q    <= 8'h00;
    end else begin
      // start, train and err are single-cycle pulses.
      start_q <= 1'b0;
      train_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_TRAIN) begin
              state_q    <= LABEL;
              is_train_q <= 1'b1;
              pix_cnt_q  <= '0;
              busy_q     <= 1'b1;
            end else if (bus.rx_data == CMD_CLASSIFY) begin
              state_q    <= PIXELS;
              is_train_q <= 1'b0;
              label_q    <= 8'h00;
              pix_cnt_q  <= '0;
              busy_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LABEL: begin
          if (bus.rx_valid) begin
            label_q <= bus.rx_data;
            state_q <= PIXELS;
          end
        end
        PIXELS: begin
          if (bus.rx_valid) begin
            if (pix_cnt_q == LAST_PX) begin
              // Raising start on entry makes it visible during the ISSUE
              // cycle, one cycle after the last pixel is registered.
              state_q <= ISSUE;
              start_q <= 1'b1;
              train_q <= is_train_q;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.rx_valid) begin
            err_q <= 1'b1;
          end
          // An early ack skips WAIT_ACK; the start pulse is already out.
          if (bus.ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.rx_valid) begin
            err_q <= 1'b1;
          end
          if (bus.ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Image is never cleared between packets; every pixel slot is rewritten
  // by the next complete packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image_q <= '0;
    end else if (pix_we) begin
      image_q[8*pix_cnt_q +: 8] <= bus.rx_data;
    end
  end

  assign bus.start     = start_q;
  assign bus.train     = train_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.label_out = label_q;
  assign bus.image_out = image_q;

endmodule
